// File: rtl/timer_unit_multi.sv
// timer_unit_multi
//   Generic-width timer/counter with NUM_CH compare channels. Supports normal,
//   CTC, fast PWM and phase-correct PWM waveform modes. PWM modes use
//   double-buffered compare registers. Overflow and compare-match flags are
//   sticky. A counter write port is provided. A prescaler generates a
//   one-cycle tick enable; every flop runs on clk.
// Ports
//   clk         system clock, all state on posedge
//   reset       asynchronous active-low clear of all state
//   mode        waveform mode (0 normal, 1/5 phase-correct, 2 CTC, 3/7 fast, 4/6 reserved)
//   cs          clock select (0 stop, 1 every clk, 2..5 prescaled /8 /64 /256 /1024)
//   com         compare output mode per channel, channel i at [2i+1:2i]
//   ocr         compare values, channel i at [CNT_WIDTH*i +: CNT_WIDTH]
//   presc_clr   synchronous prescaler clear
//   tcnt_we     load counter from tcnt_wdata (suppresses matches/tov that edge)
//   tcnt_wdata  counter load value
//   tov_clr     clear overflow flag
//   ocf_clr     per-channel compare flag clear
//   tcnt        current counter value
//   oc          output compare pins
//   tov         sticky overflow flag
//   ocf         sticky compare-match flags
module timer_unit_multi #(
  parameter int CNT_WIDTH = 16,
  parameter int NUM_CH    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    mode,
  input  logic [2:0]                    cs,
  input  logic [2*NUM_CH-1:0]           com,
  input  logic [CNT_WIDTH*NUM_CH-1:0]   ocr,
  input  logic                          presc_clr,
  input  logic                          tcnt_we,
  input  logic [CNT_WIDTH-1:0]          tcnt_wdata,
  input  logic                          tov_clr,
  input  logic [NUM_CH-1:0]             ocf_clr,
  output logic [CNT_WIDTH-1:0]          tcnt,
  output logic [NUM_CH-1:0]             oc,
  output logic                          tov,
  output logic [NUM_CH-1:0]             ocf
);

  typedef enum logic [2:0] {
    MODE_NORMAL   = 3'd0,
    MODE_PC_MAX   = 3'd1,
    MODE_CTC      = 3'd2,
    MODE_FAST_MAX = 3'd3,
    MODE_RSVD4    = 3'd4,
    MODE_PC_OCR   = 3'd5,
    MODE_RSVD6    = 3'd6,
    MODE_FAST_OCR = 3'd7
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [9:0]                        presc_q, presc_d;
  logic [CNT_WIDTH-1:0]              tcnt_q, tcnt_d;
  dir_e                              dir_q, dir_d;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0]  ocr_buf_q, ocr_buf_d;
  logic [NUM_CH-1:0]                 oc_q, oc_d;
  logic [NUM_CH-1:0]                 ocf_q, ocf_d;
  logic                              tov_q, tov_d;

  mode_e                             mode_s;
  logic                              tick;
  logic                              is_pc, is_fast, is_pwm, is_rsvd;
  logic                              advance, at_top, at_bot, at_max;
  logic                              load_buf, tov_set;
  logic [CNT_WIDTH-1:0]              top;
  logic [NUM_CH-1:0]                 match;

  assign mode_s = mode_e'(mode);

  always_comb begin : prescale
    presc_d = presc_clr ? '0 : presc_q + 10'd1;
    case (cs)
      3'd1:    tick = 1'b1;
      3'd2:    tick = &presc_q[2:0];
      3'd3:    tick = &presc_q[5:0];
      3'd4:    tick = &presc_q[7:0];
      3'd5:    tick = &presc_q[9:0];
      default: tick = 1'b0;
    endcase
  end

  always_comb begin : decode
    is_pc   = (mode_s == MODE_PC_MAX) || (mode_s == MODE_PC_OCR);
    is_fast = (mode_s == MODE_FAST_MAX) || (mode_s == MODE_FAST_OCR);
    is_pwm  = is_pc || is_fast;
    is_rsvd = (mode_s == MODE_RSVD4) || (mode_s == MODE_RSVD6);
    top     = (mode_s inside {MODE_CTC, MODE_PC_OCR, MODE_FAST_OCR}) ? ocr_buf_q[0] : CNT_MAX;
    at_top  = (tcnt_q == top);
    at_bot  = (tcnt_q == '0);
    at_max  = (tcnt_q == CNT_MAX);
    // A counter write owns the edge: no advance, no match, no overflow.
    advance = tick && !tcnt_we && !is_rsvd;
    match   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      match[i] = advance && (tcnt_q == ocr_buf_q[i]);
    end
    // PWM buffers reload at TOP using the outgoing TOP (the old ocr_buf[0]).
    load_buf = (mode_s == MODE_NORMAL) || (mode_s == MODE_CTC) || (is_pwm && tick && at_top);
  end

  always_comb begin : counter
    tcnt_d  = tcnt_q;
    dir_d   = dir_q;
    tov_set = 1'b0;
    if (tcnt_we) begin
      tcnt_d = tcnt_wdata;
    end else if (advance) begin
      if (is_pc) begin
        tov_set = at_bot;
        if (top == '0) begin
          tcnt_d = '0;
          dir_d  = DIR_UP;
        end else if (dir_q == DIR_UP) begin
          // >= so a count stranded above a lowered TOP turns around at once
          if (tcnt_q >= top) begin
            tcnt_d = tcnt_q - CNT_ONE;
            dir_d  = DIR_DOWN;
          end else begin
            tcnt_d = tcnt_q + CNT_ONE;
          end
        end else if (at_bot) begin
          tcnt_d = CNT_ONE;
          dir_d  = DIR_UP;
        end else begin
          tcnt_d = tcnt_q - CNT_ONE;
        end
      end else begin
        // Above a lowered TOP the +1 runs on to MAX and wraps naturally.
        tov_set = at_top || at_max;
        tcnt_d  = at_top ? '0 : tcnt_q + CNT_ONE;
      end
    end
    if (!is_pc) begin
      dir_d = DIR_UP;
    end
  end

  always_comb begin : outputs_and_flags
    ocr_buf_d = ocr_buf_q;
    if (load_buf) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        ocr_buf_d[i] = ocr[CNT_WIDTH*i +: CNT_WIDTH];
      end
    end
    oc_d = oc_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (is_pc) begin
        if (match[i]) begin
          case (com[2*i +: 2])
            2'd1:    if (mode_s == MODE_PC_OCR && i == 0) oc_d[i] = ~oc_q[i];
            2'd2:    oc_d[i] = (dir_q == DIR_DOWN);
            2'd3:    oc_d[i] = (dir_q == DIR_UP);
            default: oc_d[i] = oc_q[i];
          endcase
        end
      end else if (is_fast) begin
        // Match is tested before BOTTOM so ocr_buf==0 keeps the match action.
        if (match[i]) begin
          case (com[2*i +: 2])
            2'd1:    if (mode_s == MODE_FAST_OCR && i == 0) oc_d[i] = ~oc_q[i];
            2'd2:    oc_d[i] = 1'b0;
            2'd3:    oc_d[i] = 1'b1;
            default: oc_d[i] = oc_q[i];
          endcase
        end else if (advance && at_bot) begin
          case (com[2*i +: 2])
            2'd2:    oc_d[i] = 1'b1;
            2'd3:    oc_d[i] = 1'b0;
            default: oc_d[i] = oc_q[i];
          endcase
        end
      end else if (match[i]) begin
        case (com[2*i +: 2])
          2'd1:    oc_d[i] = ~oc_q[i];
          2'd2:    oc_d[i] = 1'b0;
          2'd3:    oc_d[i] = 1'b1;
          default: oc_d[i] = oc_q[i];
        endcase
      end
    end
    ocf_d = match | (ocf_q & ~ocf_clr);
    tov_d = tov_set | (tov_q & ~tov_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q   <= '0;
      tcnt_q    <= '0;
      dir_q     <= DIR_UP;
      ocr_buf_q <= '0;
      oc_q      <= '0;
      ocf_q     <= '0;
      tov_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      tcnt_q    <= tcnt_d;
      dir_q     <= dir_d;
      ocr_buf_q <= ocr_buf_d;
      oc_q      <= oc_d;
      ocf_q     <= ocf_d;
      tov_q     <= tov_d;
    end
  end

  assign tcnt = tcnt_q;
  assign oc   = oc_q;
  assign tov  = tov_q;
  assign ocf  = ocf_q;

endmodule

// File: tb/tb_timer_unit_multi.sv
// Testbench for timer_unit_multi (8-bit counter, 3 channels).
module tb_timer_unit_multi;
  localparam int W    = 8;
  localparam int N    = 3;
  localparam int CW   = 2 * N;
  localparam int MAXV = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [2:0]     mode, cs;
  logic [CW-1:0]  com;
  logic [W*N-1:0] ocr;
  logic           presc_clr, tcnt_we, tov_clr;
  logic [W-1:0]   tcnt_wdata;
  logic [N-1:0]   ocf_clr;
  logic [W-1:0]   tcnt;
  logic [N-1:0]   oc, ocf;
  logic           tov;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int           m_cnt, m_presc;
  bit           m_up;
  int           m_buf [N];
  logic [N-1:0] m_oc, m_ocf;
  logic         m_tov;

  timer_unit_multi #(.CNT_WIDTH(W), .NUM_CH(N)) dut (
    .clk(clk), .reset(reset), .mode(mode), .cs(cs), .com(com), .ocr(ocr),
    .presc_clr(presc_clr), .tcnt_we(tcnt_we), .tcnt_wdata(tcnt_wdata),
    .tov_clr(tov_clr), .ocf_clr(ocf_clr), .tcnt(tcnt), .oc(oc), .tov(tov), .ocf(ocf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0; m_presc = 0; m_up = 1'b1;
    for (int i = 0; i < N; i++) m_buf[i] = 0;
    m_oc = '0; m_ocf = '0; m_tov = 1'b0;
  endtask

  // One clock of the timer described by its rules, using integer arithmetic.
  task automatic model_step();
    bit tk, pc, fast, rsv, pwm, tov_set, load_buf;
    int top, oldc, c;
    logic [N-1:0] hit;
    case (cs)
      3'd1:    tk = 1'b1;
      3'd2:    tk = (m_presc % 8) == 7;
      3'd3:    tk = (m_presc % 64) == 63;
      3'd4:    tk = (m_presc % 256) == 255;
      3'd5:    tk = (m_presc % 1024) == 1023;
      default: tk = 1'b0;
    endcase
    m_presc  = presc_clr ? 0 : (m_presc + 1) % 1024;
    pc       = (mode == 3'd1) || (mode == 3'd5);
    fast     = (mode == 3'd3) || (mode == 3'd7);
    rsv      = (mode == 3'd4) || (mode == 3'd6);
    pwm      = pc || fast;
    top      = (mode == 3'd2 || mode == 3'd5 || mode == 3'd7) ? m_buf[0] : MAXV;
    oldc     = m_cnt;
    tov_set  = 1'b0;
    hit      = '0;
    load_buf = (mode == 3'd0) || (mode == 3'd2) || (pwm && tk && oldc == top);
    if (tcnt_we) begin
      m_cnt = int'(tcnt_wdata);
    end else if (tk && !rsv) begin
      for (int i = 0; i < N; i++) hit[i] = (oldc == m_buf[i]);
      for (int i = 0; i < N; i++) begin
        c = int'(com[2*i +: 2]);
        if (pc) begin
          if (hit[i]) begin
            if (c == 2) m_oc[i] = !m_up;
            else if (c == 3) m_oc[i] = m_up;
            else if (c == 1 && mode == 3'd5 && i == 0) m_oc[i] = !m_oc[i];
          end
        end else if (fast) begin
          if (hit[i]) begin
            if (c == 2) m_oc[i] = 1'b0;
            else if (c == 3) m_oc[i] = 1'b1;
            else if (c == 1 && mode == 3'd7 && i == 0) m_oc[i] = !m_oc[i];
          end else if (oldc == 0) begin
            if (c == 2) m_oc[i] = 1'b1;
            else if (c == 3) m_oc[i] = 1'b0;
          end
        end else if (hit[i]) begin
          if (c == 1) m_oc[i] = !m_oc[i];
          else if (c == 2) m_oc[i] = 1'b0;
          else if (c == 3) m_oc[i] = 1'b1;
        end
      end
      if (pc) begin
        tov_set = (oldc == 0);
        if (top == 0) begin m_cnt = 0; m_up = 1'b1; end
        else if (m_up && oldc < top) m_cnt = oldc + 1;
        else if (m_up) begin m_cnt = oldc - 1; m_up = 1'b0; end
        else if (oldc == 0) begin m_cnt = 1; m_up = 1'b1; end
        else m_cnt = oldc - 1;
      end else begin
        tov_set = (oldc == top) || (oldc == MAXV);
        m_cnt   = (oldc == top) ? 0 : (oldc + 1) % (MAXV + 1);
      end
    end
    if (load_buf) for (int i = 0; i < N; i++) m_buf[i] = int'(ocr[W*i +: W]);
    if (!pc) m_up = 1'b1;
    m_tov = tov_set | (m_tov & !tov_clr);
    m_ocf = hit | (m_ocf & ~ocf_clr);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_ocr(input int ch, input int v);
    ocr[W*ch +: W] = W'(v);
  endtask

  task automatic set_com(input int ch, input int v);
    com[2*ch +: 2] = 2'(v);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    #2;
    n_cmp++; if (tcnt !== '0) begin n_bad++; $display("FAIL reset_tcnt got=%0d exp=0", tcnt); end
    n_cmp++; if (oc !== '0)   begin n_bad++; $display("FAIL reset_oc got=%b exp=000", oc); end
    n_cmp++; if (tov !== 1'b0) begin n_bad++; $display("FAIL reset_tov got=%b exp=0", tov); end
    n_cmp++; if (ocf !== '0)  begin n_bad++; $display("FAIL reset_ocf got=%b exp=000", ocf); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_normal_wrap();
    mode = 3'd0; cs = 3'd1; com = '0; ocr = '0;
    tcnt_we = 1'b1; tcnt_wdata = 8'd250;
    cycle();
    tcnt_we = 1'b0;
    n_cmp++; if (tcnt !== 8'd250) begin n_bad++; $display("FAIL wrap_load got=%0d exp=250", tcnt); end
    for (int k = 0; k < 6; k++) begin
      cycle();
      n_cmp++;
      if ({tcnt, oc, tov, ocf} !== {W'(m_cnt), m_oc, m_tov, m_ocf}) begin
        n_bad++; $display("FAIL wrap_step k=%0d got=%h exp=%h", k, {tcnt, oc, tov, ocf}, {W'(m_cnt), m_oc, m_tov, m_ocf});
      end
    end
    n_cmp++; if (tcnt !== 8'd0) begin n_bad++; $display("FAIL wrap_zero got=%0d exp=0", tcnt); end
    n_cmp++; if (tov !== 1'b1) begin n_bad++; $display("FAIL wrap_tov got=%b exp=1", tov); end
    tov_clr = 1'b1;
    cycle();
    tov_clr = 1'b0;
    n_cmp++; if (tov !== 1'b0) begin n_bad++; $display("FAIL wrap_tov_clr got=%b exp=0", tov); end
  endtask

  task automatic test_ctc();
    int toggles;
    logic prev;
    mode = 3'd2; cs = 3'd2; com = '0; set_com(0, 1);
    set_ocr(0, 4); set_ocr(1, 200); set_ocr(2, 3);
    presc_clr = 1'b1; tcnt_we = 1'b1; tcnt_wdata = '0; ocf_clr = '1;
    cycle();
    presc_clr = 1'b0; tcnt_we = 1'b0; ocf_clr = '0;
    prev = oc[0];
    toggles = 0;
    for (int k = 0; k < 160; k++) begin
      cycle();
      if (oc[0] !== prev) toggles++;
      prev = oc[0];
      n_cmp++;
      if ({tcnt, oc, tov, ocf} !== {W'(m_cnt), m_oc, m_tov, m_ocf}) begin
        n_bad++; $display("FAIL ctc k=%0d got=%h exp=%h", k, {tcnt, oc, tov, ocf}, {W'(m_cnt), m_oc, m_tov, m_ocf});
      end
    end
    // 20 ticks at /8, a toggle every 5th tick
    n_cmp++; if (toggles != 4) begin n_bad++; $display("FAIL ctc_toggles got=%0d exp=4", toggles); end
    n_cmp++; if (tcnt !== 8'd0) begin n_bad++; $display("FAIL ctc_end_tcnt got=%0d exp=0", tcnt); end
    n_cmp++; if (ocf[0] !== 1'b1) begin n_bad++; $display("FAIL ctc_ocf got=%b exp=1", ocf[0]); end
  endtask

  task automatic test_fast_pwm();
    mode = 3'd3; cs = 3'd1; com = '0; set_com(1, 2); set_com(2, 3);
    set_ocr(1, 64); set_ocr(2, 0);
    tcnt_we = 1'b1; tcnt_wdata = '0;
    cycle();
    tcnt_we = 1'b0;
    for (int k = 0; k < 600; k++) begin
      cycle();
      n_cmp++;
      if ({tcnt, oc, tov, ocf} !== {W'(m_cnt), m_oc, m_tov, m_ocf}) begin
        n_bad++; $display("FAIL fast k=%0d got=%h exp=%h", k, {tcnt, oc, tov, ocf}, {W'(m_cnt), m_oc, m_tov, m_ocf});
      end
    end
  endtask

  task automatic test_pc_pwm();
    mode = 3'd1; cs = 3'd1; com = '0; set_com(2, 2); set_com(1, 3);
    set_ocr(2, 10); set_ocr(1, 255);
    tcnt_we = 1'b1; tcnt_wdata = '0;
    cycle();
    tcnt_we = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      cycle();
      n_cmp++;
      if ({tcnt, oc, tov, ocf} !== {W'(m_cnt), m_oc, m_tov, m_ocf}) begin
        n_bad++; $display("FAIL pc k=%0d got=%h exp=%h", k, {tcnt, oc, tov, ocf}, {W'(m_cnt), m_oc, m_tov, m_ocf});
      end
    end
  endtask

  task automatic test_buffer_update();
    mode = 3'd0; cs = 3'd1; com = '0; set_ocr(0, 100);
    tcnt_we = 1'b1; tcnt_wdata = '0;
    cycle();
    tcnt_we = 1'b0; mode = 3'd7;
    for (int k = 0; k < 30; k++) cycle();
    set_ocr(0, 50);
    for (int k = 0; k < 70; k++) begin
      cycle();
      n_cmp++;
      if ({tcnt, oc, tov, ocf} !== {W'(m_cnt), m_oc, m_tov, m_ocf}) begin
        n_bad++; $display("FAIL buf k=%0d got=%h exp=%h", k, {tcnt, oc, tov, ocf}, {W'(m_cnt), m_oc, m_tov, m_ocf});
      end
    end
    n_cmp++; if (tcnt !== 8'd100) begin n_bad++; $display("FAIL buf_old_top got=%0d exp=100", tcnt); end
    cycle();
    n_cmp++; if (tcnt !== 8'd0) begin n_bad++; $display("FAIL buf_wrap1 got=%0d exp=0", tcnt); end
    for (int k = 0; k < 50; k++) cycle();
    n_cmp++; if (tcnt !== 8'd50) begin n_bad++; $display("FAIL buf_new_top got=%0d exp=50", tcnt); end
    cycle();
    n_cmp++; if (tcnt !== 8'd0) begin n_bad++; $display("FAIL buf_wrap2 got=%0d exp=0", tcnt); end
  endtask

  task automatic test_we_suppress();
    mode = 3'd0; cs = 3'd1; com = '0; set_com(0, 1); set_ocr(0, 20);
    ocf_clr = '1; tov_clr = 1'b1; tcnt_we = 1'b1; tcnt_wdata = 8'd20;
    cycle();
    ocf_clr = '0; tov_clr = 1'b0;
    cycle();
    n_cmp++; if (ocf[0] !== 1'b0) begin n_bad++; $display("FAIL we_no_match got=%b exp=0", ocf[0]); end
    n_cmp++; if (oc[0] !== m_oc[0]) begin n_bad++; $display("FAIL we_oc_hold got=%b exp=%b", oc[0], m_oc[0]); end
    n_cmp++; if (tcnt !== 8'd20) begin n_bad++; $display("FAIL we_tcnt got=%0d exp=20", tcnt); end
    tcnt_we = 1'b0;
    cycle();
    n_cmp++; if (ocf[0] !== 1'b1) begin n_bad++; $display("FAIL we_release_match got=%b exp=1", ocf[0]); end
    n_cmp++; if (tcnt !== 8'd21) begin n_bad++; $display("FAIL we_release_tcnt got=%0d exp=21", tcnt); end
    tcnt_we = 1'b1; tcnt_wdata = 8'd255;
    cycle();
    cycle();
    n_cmp++; if (tov !== 1'b0) begin n_bad++; $display("FAIL we_no_tov got=%b exp=0", tov); end
    tcnt_we = 1'b0;
    cycle();
    n_cmp++; if ({tcnt, tov} !== {8'd0, 1'b1}) begin n_bad++; $display("FAIL we_release_tov got=%h exp=%h", {tcnt, tov}, {8'd0, 1'b1}); end
  endtask

  task automatic test_prescale();
    int div;
    mode = 3'd0; com = '0;
    for (int s = 2; s <= 5; s++) begin
      div = (s == 2) ? 8 : (s == 3) ? 64 : (s == 4) ? 256 : 1024;
      cs = 3'(s); presc_clr = 1'b1; tcnt_we = 1'b1; tcnt_wdata = '0;
      cycle();
      presc_clr = 1'b0; tcnt_we = 1'b0;
      for (int k = 0; k < div - 1; k++) cycle();
      n_cmp++; if (tcnt !== 8'd0) begin n_bad++; $display("FAIL presc_before cs=%0d got=%0d exp=0", s, tcnt); end
      cycle();
      n_cmp++; if (tcnt !== 8'd1) begin n_bad++; $display("FAIL presc_tick cs=%0d got=%0d exp=1", s, tcnt); end
    end
    cs = 3'd0;
    for (int k = 0; k < 40; k++) cycle();
    n_cmp++; if (tcnt !== 8'd1) begin n_bad++; $display("FAIL presc_stop got=%0d exp=1", tcnt); end
  endtask

  task automatic test_random();
    int ch;
    for (int k = 0; k < 3000; k++) begin
      if (k % 150 == 0) begin
        mode = 3'($urandom_range(0, 7));
        cs   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 5)) : 3'd1;
        com  = CW'($urandom);
      end
      if ($urandom_range(0, 19) == 0) begin
        ch = int'($urandom_range(0, N - 1));
        set_ocr(ch, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, MAXV)));
      end
      tcnt_we    = ($urandom_range(0, 49) == 0);
      tcnt_wdata = W'($urandom);
      tov_clr    = ($urandom_range(0, 9) == 0);
      ocf_clr    = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
      presc_clr  = ($urandom_range(0, 39) == 0);
      cycle();
      n_cmp++;
      if ({tcnt, oc, tov, ocf} !== {W'(m_cnt), m_oc, m_tov, m_ocf}) begin
        n_bad++; $display("FAIL rand k=%0d mode=%0d got=%h exp=%h", k, mode, {tcnt, oc, tov, ocf}, {W'(m_cnt), m_oc, m_tov, m_ocf});
      end
    end
    tcnt_we = 1'b0; tov_clr = 1'b0; ocf_clr = '0; presc_clr = 1'b0;
  endtask

  task automatic test_midcount_reset();
    mode = 3'd0; cs = 3'd1; com = '0; set_com(0, 3); set_ocr(0, 5);
    tcnt_we = 1'b1; tcnt_wdata = '0;
    cycle();
    tcnt_we = 1'b0;
    for (int k = 0; k < 20; k++) cycle();
    n_cmp++;
    if ({tcnt, oc, tov, ocf} !== {W'(m_cnt), m_oc, m_tov, m_ocf}) begin
      n_bad++; $display("FAIL midreset_pre got=%h exp=%h", {tcnt, oc, tov, ocf}, {W'(m_cnt), m_oc, m_tov, m_ocf});
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({tcnt, oc, tov, ocf} !== '0) begin n_bad++; $display("FAIL midreset_clear got=%h exp=0", {tcnt, oc, tov, ocf}); end
    model_reset();
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      n_cmp++;
      if ({tcnt, oc, tov, ocf} !== {W'(m_cnt), m_oc, m_tov, m_ocf}) begin
        n_bad++; $display("FAIL midreset_post k=%0d got=%h exp=%h", k, {tcnt, oc, tov, ocf}, {W'(m_cnt), m_oc, m_tov, m_ocf});
      end
    end
  endtask

  initial begin
    reset = 1'b1; mode = '0; cs = '0; com = '0; ocr = '0;
    presc_clr = 1'b0; tcnt_we = 1'b0; tcnt_wdata = '0; tov_clr = 1'b0; ocf_clr = '0;
    model_reset();
    test_reset();
    test_normal_wrap();
    test_ctc();
    test_fast_pwm();
    test_pc_pwm();
    test_buffer_update();
    test_we_suppress();
    test_prescale();
    test_random();
    test_midcount_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
